// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display stage: FSM encoding, 7-seg glyphs, digit positions.
// Pure definitions; no latency or flow control.
package calc_disp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    localparam int DIG_SIGN = 4;
    localparam int DIG_HUND = 2;
    localparam int DIG_TENS = 1;
    localparam int DIG_UNIT = 0;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one bit per cycle.
// Latency: 8 cycles after start; done and bcd are valid together in the 8th cycle; no backpressure.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [11:0] adj;
    logic [19:0] sh;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        sh = {adj, bin_q} << 1;

        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            bin_d = bin;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = sh[19:8];
            bin_d = sh[7:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_d = 1'b0;
            end
        end
    end

    // Result is exposed combinationally so the caller can commit on the final shift edge.
    assign bcd  = sh[19:8];
    assign done = run_q && (cnt_q == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Calculator result display: latch on load, BCD-convert, scan a 5-digit 7-seg. Optional LEADING_ZERO_BLANK_EN.
// Latency: digits commit 9 edges after load; load during conversion is dropped, no queuing.
module bcd_scan_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit SIGNED_IN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       valid,
    output logic [6:0] seg_out,
    output logic [4:0] seg_sel
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic             sign_q, sign_d;
    logic             valid_q, valid_d;
    logic [11:0]      shadow_q, shadow_d;
    logic             shadow_sign_q, shadow_sign_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [4:0]       sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;

    logic        neg_in;
    logic [7:0]  mag_in;
    logic        start;
    logic [11:0] conv_bcd;
    logic        conv_done;
    logic        hund_blank, tens_blank;
    logic        ref_tc;
    logic [4:0]  sel_nxt;
    logic [6:0]  glyph [5];

    assign neg_in = SIGNED_IN && data_in[7];
    assign mag_in = neg_in ? (~data_in + 8'd1) : data_in;
    assign start  = load && (state_q != ST_CONV);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (mag_in),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        valid_d       = valid_q;
        shadow_d      = shadow_q;
        shadow_sign_d = shadow_sign_q;
        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (load) begin
                    sign_d  = neg_in;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    shadow_d      = conv_bcd;
                    shadow_sign_d = sign_q;
                    valid_d       = 1'b1;
                    state_d       = ST_SHOW;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hund_blank = 1'b0;
        tens_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        hund_blank = (shadow_q[11:8] == 4'd0);
        tens_blank = hund_blank && (shadow_q[7:4] == 4'd0);
`endif
        glyph[DIG_SIGN] = shadow_sign_q ? SEG_MINUS : SEG_BLANK;
        glyph[3]        = SEG_BLANK;
        glyph[DIG_HUND] = hund_blank ? SEG_BLANK : bcd_glyph(shadow_q[11:8]);
        glyph[DIG_TENS] = tens_blank ? SEG_BLANK : bcd_glyph(shadow_q[7:4]);
        glyph[DIG_UNIT] = bcd_glyph(shadow_q[3:0]);
        if (!valid_q) begin
            for (int i = 0; i < 5; i++) begin
                glyph[i] = SEG_BLANK;
            end
        end
    end

    // Select and glyph move on the same edge so they never disagree.
    always_comb begin
        ref_tc    = (ref_cnt_q == CNT_LAST);
        ref_cnt_d = ref_tc ? '0 : ref_cnt_q + CNT_W'(1);
        sel_nxt   = {sel_q[3:0], sel_q[4]};
        sel_d     = sel_q;
        seg_d     = seg_q;
        if (ref_tc) begin
            sel_d = sel_nxt;
            seg_d = SEG_BLANK;
            for (int i = 0; i < 5; i++) begin
                if (sel_nxt[i]) begin
                    seg_d = seg_d | glyph[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sign_q        <= 1'b0;
            valid_q       <= 1'b0;
            shadow_q      <= '0;
            shadow_sign_q <= 1'b0;
            ref_cnt_q     <= '0;
            sel_q         <= 5'b00001;
            seg_q         <= SEG_BLANK;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            valid_q       <= valid_d;
            shadow_q      <= shadow_d;
            shadow_sign_q <= shadow_sign_d;
            ref_cnt_q     <= ref_cnt_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
        end
    end

    assign busy    = (state_q == ST_CONV);
    assign valid   = valid_q;
    assign seg_out = seg_q;
    assign seg_sel = sel_q;

endmodule
